// File: rtl/fmul_unpack_mul.sv
// fmul front end: unpacks two IEEE-754 singles, decodes special cases,
// forms sign and biased exponent sum, and builds the 24x24 mantissa
// product iteratively, BITS_PER_CYCLE multiplier bits per cycle.
// One result record is handed to the normalise/round stage over valid/ready.

// Per-operand unpack: hidden bit, effective exponent, class flags.
module fmul_unpack (
  input  logic [31:0] x,
  output logic [23:0] m,
  output logic [7:0]  e_eff,
  output logic        nan,
  output logic        inf,
  output logic        zero
);
  logic [7:0]  e;
  logic [22:0] f;

  assign e     = x[30:23];
  assign f     = x[22:0];
  assign m     = {|e, f};
  // denormals use exponent 1 and are not pre-normalised
  assign e_eff = (e == 8'd0) ? 8'd1 : e;
  assign nan   = (e == 8'hFF) && (f != 23'd0);
  assign inf   = (e == 8'hFF) && (f == 23'd0);
  assign zero  = (e == 8'd0)  && (f == 23'd0);
endmodule

module fmul_unpack_mul #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  rm_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] z,
  output logic [9:0]  exp10,
  output logic        sign,
  output logic        is_nan,
  output logic        is_inf,
  output logic [22:0] inf_nan_frac,
  output logic [1:0]  rm
);
  localparam int K  = BITS_PER_CYCLE;
  localparam int N  = 24 / K;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // result record presented to the norm stage
  typedef struct packed {
    logic [47:0] z;
    logic [9:0]  exp10;
    logic        sign;
    logic        is_nan;
    logic        is_inf;
    logic [22:0] frac;
    logic [1:0]  rm;
  } rec_t;

  state_t state_q, state_d;
  rec_t   rec_q;

  logic [23:0] m_a_q, m_b_q;
  logic [47:0] acc_q, acc_next, pp;
  logic [CW-1:0] cnt_q;
  logic last, accept;

  // operand lanes: index 0 is a, index 1 is b
  logic [1:0][31:0] ops;
  logic [1:0][23:0] m_in;
  logic [1:0][7:0]  e_in;
  logic [1:0]       nan_in, inf_in, zero_in;

  assign ops = {b, a};

  genvar i;
  generate
    for (i = 0; i < 2; i++) begin : g_unp
      fmul_unpack u_unp (
        .x     (ops[i]),
        .m     (m_in[i]),
        .e_eff (e_in[i]),
        .nan   (nan_in[i]),
        .inf   (inf_in[i]),
        .zero  (zero_in[i])
      );
    end
  endgenerate

  logic [9:0] exp_sum;
  logic       nan_any, inf_any, shortcut;

  assign exp_sum  = {2'b00, e_in[0]} + {2'b00, e_in[1]} - 10'd127;
  assign nan_any  = (|nan_in) | (inf_in[0] & zero_in[1]) | (inf_in[1] & zero_in[0]);
  assign inf_any  = |inf_in;
  // specials and zeros need no multiply: result record is complete at accept
  assign shortcut = nan_any | inf_any | (|zero_in);

  assign accept = in_valid & in_ready;
  assign last   = (cnt_q == CW'(N - 1));

  // one radix-2^K step: shift accumulator, add m_b times the top K bits of m_a
  assign pp       = 48'(m_b_q) * 48'(m_a_q[23 -: K]);
  assign acc_next = (acc_q << K) + pp;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = shortcut ? DONE : BUSY;
      BUSY: if (last)   state_d = DONE;
      DONE: begin
        if (out_ready) begin
          if (accept) state_d = shortcut ? DONE : BUSY;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // handshake outputs
  always_comb begin
    in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    out_valid = (state_q == DONE);
  end

  // operand latch, iterative multiply and result record
  always_ff @(posedge clk) begin
    if (rst) begin
      rec_q <= '0;
      m_a_q <= '0;
      m_b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      m_a_q        <= m_in[0];
      m_b_q        <= m_in[1];
      acc_q        <= '0;
      cnt_q        <= '0;
      rec_q.z      <= '0;
      rec_q.exp10  <= exp_sum;
      rec_q.sign   <= a[31] ^ b[31];
      rec_q.is_nan <= nan_any;
      rec_q.is_inf <= inf_any;
      rec_q.frac   <= nan_any ? 23'h400000 : 23'd0;
      rec_q.rm     <= rm_in;
    end else if (state_q == BUSY) begin
      acc_q <= acc_next;
      m_a_q <= m_a_q << K;
      cnt_q <= cnt_q + CW'(1);
      if (last) rec_q.z <= acc_next;
    end
  end

  assign z            = rec_q.z;
  assign exp10        = rec_q.exp10;
  assign sign         = rec_q.sign;
  assign is_nan       = rec_q.is_nan;
  assign is_inf       = rec_q.is_inf;
  assign inf_nan_frac = rec_q.frac;
  assign rm           = rec_q.rm;
endmodule

// File: tb/tb_fmul_unpack_mul.sv
// Directed bench for fmul_unpack_mul: main instance at 4 bits/cycle plus
// 1, 8 and 24 bits/cycle instances for the width sweep.
module tb_fmul_unpack_mul;
  logic clk = 0;
  logic rst = 1;
  logic [31:0] a = 0, b = 0;
  logic [1:0]  rm_in = 0;
  logic in_valid = 0, out_ready = 0;
  logic in_valid_s = 0, out_ready_s = 0;

  logic        in_ready, out_valid, sign, is_nan, is_inf;
  logic [47:0] z;
  logic [9:0]  exp10;
  logic [22:0] inf_nan_frac;
  logic [1:0]  rm;

  logic        s_in_ready[3], s_out_valid[3], s_sign[3], s_nan[3], s_inf[3];
  logic [47:0] s_z[3];
  logic [9:0]  s_exp[3];
  logic [22:0] s_frac[3];
  logic [1:0]  s_rm[3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fmul_unpack_mul #(.BITS_PER_CYCLE(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .rm_in(rm_in),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .exp10(exp10), .sign(sign), .is_nan(is_nan), .is_inf(is_inf),
    .inf_nan_frac(inf_nan_frac), .rm(rm));

  fmul_unpack_mul #(.BITS_PER_CYCLE(1)) u_k1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .rm_in(rm_in),
    .in_valid(in_valid_s), .in_ready(s_in_ready[0]), .out_valid(s_out_valid[0]), .out_ready(out_ready_s),
    .z(s_z[0]), .exp10(s_exp[0]), .sign(s_sign[0]), .is_nan(s_nan[0]), .is_inf(s_inf[0]),
    .inf_nan_frac(s_frac[0]), .rm(s_rm[0]));

  fmul_unpack_mul #(.BITS_PER_CYCLE(8)) u_k8 (
    .clk(clk), .rst(rst), .a(a), .b(b), .rm_in(rm_in),
    .in_valid(in_valid_s), .in_ready(s_in_ready[1]), .out_valid(s_out_valid[1]), .out_ready(out_ready_s),
    .z(s_z[1]), .exp10(s_exp[1]), .sign(s_sign[1]), .is_nan(s_nan[1]), .is_inf(s_inf[1]),
    .inf_nan_frac(s_frac[1]), .rm(s_rm[1]));

  fmul_unpack_mul #(.BITS_PER_CYCLE(24)) u_k24 (
    .clk(clk), .rst(rst), .a(a), .b(b), .rm_in(rm_in),
    .in_valid(in_valid_s), .in_ready(s_in_ready[2]), .out_valid(s_out_valid[2]), .out_ready(out_ready_s),
    .z(s_z[2]), .exp10(s_exp[2]), .sign(s_sign[2]), .is_nan(s_nan[2]), .is_inf(s_inf[2]),
    .inf_nan_frac(s_frac[2]), .rm(s_rm[2]));

  // cycles from the first edge until out_valid; returns limit on timeout
  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < limit);
  endtask

  // consume the record with no new operands
  task automatic release_rec();
    in_valid  = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    total++; if (z !== 48'd0 || exp10 !== 10'd0) begin bad++; $display("FAIL rst_z_exp got=%h/%h exp=0/0", z, exp10); end
    total++; if ({sign, is_nan, is_inf, inf_nan_frac, rm} !== 28'd0) begin bad++; $display("FAIL rst_flags got=%b%b%b %h %0d exp=0", sign, is_nan, is_inf, inf_nan_frac, rm); end
    total++; if ({s_out_valid[0], s_out_valid[1], s_out_valid[2]} !== 3'b000) begin bad++; $display("FAIL rst_sweep_valid got=%b%b%b exp=000", s_out_valid[0], s_out_valid[1], s_out_valid[2]); end
    rst = 0;
  endtask

  task automatic test_basic();
    int cyc;
    a = 32'h3FC00000; b = 32'h40000000; rm_in = 2'd2; in_valid = 1;
    wait_valid(40, cyc);
    in_valid = 0;
    total++; if (cyc !== 7) begin bad++; $display("FAIL basic_latency got=%0d exp=7", cyc); end
    total++; if (z !== 48'h600000000000) begin bad++; $display("FAIL basic_z got=%h exp=600000000000", z); end
    total++; if (exp10 !== 10'h080) begin bad++; $display("FAIL basic_exp got=%h exp=080", exp10); end
    total++; if ({sign, is_nan, is_inf} !== 3'b000) begin bad++; $display("FAIL basic_flags got=%b%b%b exp=000", sign, is_nan, is_inf); end
    total++; if (rm !== 2'd2) begin bad++; $display("FAIL basic_rm got=%0d exp=2", rm); end
    release_rec();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL basic_idle got=%b%b exp=01", out_valid, in_ready); end
  endtask

  task automatic test_sign();
    int cyc;
    a = 32'hBF800000; b = 32'h3F800000; rm_in = 2'd1; in_valid = 1;
    wait_valid(40, cyc);
    in_valid = 0;
    total++; if (cyc !== 7) begin bad++; $display("FAIL sign_latency got=%0d exp=7", cyc); end
    total++; if (z !== 48'h400000000000) begin bad++; $display("FAIL sign_z got=%h exp=400000000000", z); end
    total++; if (exp10 !== 10'h07F) begin bad++; $display("FAIL sign_exp got=%h exp=07f", exp10); end
    total++; if ({sign, is_nan, is_inf} !== 3'b100) begin bad++; $display("FAIL sign_flags got=%b%b%b exp=100", sign, is_nan, is_inf); end
    total++; if (rm !== 2'd1) begin bad++; $display("FAIL sign_rm got=%0d exp=1", rm); end
    release_rec();
  endtask

  task automatic test_special();
    logic [31:0] va[4], vb[4];
    logic [9:0]  ve[4];
    logic [2:0]  vf[4];
    logic [22:0] vfr[4];
    int cyc;
    // inf*0, NaN*1, 0*1, -inf*2
    va[0] = 32'h7F800000; vb[0] = 32'h00000000; ve[0] = 10'h081; vf[0] = 3'b011; vfr[0] = 23'h400000;
    va[1] = 32'h7FC00000; vb[1] = 32'h3F800000; ve[1] = 10'h0FF; vf[1] = 3'b010; vfr[1] = 23'h400000;
    va[2] = 32'h00000000; vb[2] = 32'h3F800000; ve[2] = 10'h001; vf[2] = 3'b000; vfr[2] = 23'h000000;
    va[3] = 32'hFF800000; vb[3] = 32'h40000000; ve[3] = 10'h100; vf[3] = 3'b101; vfr[3] = 23'h000000;
    for (int k = 0; k < 4; k++) begin
      a = va[k]; b = vb[k]; in_valid = 1;
      wait_valid(40, cyc);
      in_valid = 0;
      total++; if (cyc !== 1) begin bad++; $display("FAIL special%0d_latency got=%0d exp=1", k, cyc); end
      total++; if ({sign, is_nan, is_inf} !== vf[k]) begin bad++; $display("FAIL special%0d_flags got=%b%b%b exp=%b", k, sign, is_nan, is_inf, vf[k]); end
      total++; if (inf_nan_frac !== vfr[k]) begin bad++; $display("FAIL special%0d_frac got=%h exp=%h", k, inf_nan_frac, vfr[k]); end
      total++; if (z !== 48'd0 || exp10 !== ve[k]) begin bad++; $display("FAIL special%0d_z_exp got=%h/%h exp=0/%h", k, z, exp10, ve[k]); end
      release_rec();
    end
  endtask

  task automatic test_sweep();
    logic [31:0] va[2], vb[2];
    logic [47:0] vz[2];
    logic [9:0]  ve[2];
    int lat[3], explat[3], cyc;
    va[0] = 32'h00000001; vb[0] = 32'h3F800000; vz[0] = 48'h000000800000; ve[0] = 10'h001;
    va[1] = 32'h3FFFFFFF; vb[1] = 32'h3FFFFFFF; vz[1] = 48'hFFFFFE000001; ve[1] = 10'h07F;
    explat[0] = 25; explat[1] = 4; explat[2] = 2;
    for (int k = 0; k < 2; k++) begin
      a = va[k]; b = vb[k]; in_valid = 1;
      wait_valid(40, cyc);
      in_valid = 0;
      total++; if (cyc !== 7) begin bad++; $display("FAIL sweep%0d_k4_latency got=%0d exp=7", k, cyc); end
      total++; if (z !== vz[k] || exp10 !== ve[k]) begin bad++; $display("FAIL sweep%0d_k4 got=%h/%h exp=%h/%h", k, z, exp10, vz[k], ve[k]); end
      release_rec();
      for (int i = 0; i < 3; i++) lat[i] = 0;
      in_valid_s = 1;
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk); #1;
        if (c == 1) in_valid_s = 0;
        for (int i = 0; i < 3; i++) if (s_out_valid[i] && lat[i] == 0) lat[i] = c;
        if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      end
      for (int i = 0; i < 3; i++) begin
        total++; if (lat[i] !== explat[i]) begin bad++; $display("FAIL sweep%0d_lat%0d got=%0d exp=%0d", k, i, lat[i], explat[i]); end
        total++; if (s_z[i] !== vz[k] || s_exp[i] !== ve[k]) begin bad++; $display("FAIL sweep%0d_z%0d got=%h/%h exp=%h/%h", k, i, s_z[i], s_exp[i], vz[k], ve[k]); end
      end
      out_ready_s = 1;
      @(posedge clk); #1;
      out_ready_s = 0;
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    a = 32'h3FC00000; b = 32'h40000000; in_valid = 1;
    wait_valid(40, cyc);
    total++; if (cyc !== 7) begin bad++; $display("FAIL bp_latency got=%0d exp=7", cyc); end
    a = 32'hBF800000; b = 32'h3F800000;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || z !== 48'h600000000000 || sign !== 1'b0 || exp10 !== 10'h080) begin
        bad++; $display("FAIL bp_hold%0d got=v%b r%b z=%h s=%b e=%h exp=v1 r0 z=600000000000 s=0 e=080", k, out_valid, in_ready, z, sign, exp10);
      end
    end
    out_ready = 1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_comb got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    out_ready = 0; in_valid = 0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_accept got=v%b r%b exp=v0 r0", out_valid, in_ready); end
    wait_valid(40, cyc);
    total++; if (cyc !== 6) begin bad++; $display("FAIL bp_latency2 got=%0d exp=6", cyc); end
    total++; if (z !== 48'h400000000000 || sign !== 1'b1 || exp10 !== 10'h07F) begin bad++; $display("FAIL bp_result got=%h/%b/%h exp=400000000000/1/07f", z, sign, exp10); end
    release_rec();
  endtask

  task automatic test_back_to_back();
    int cyc;
    a = 32'h3FC00000; b = 32'h40000000; in_valid = 1;
    wait_valid(40, cyc);
    // consume and accept a shortcut operand pair on the same edge
    a = 32'h7F800000; b = 32'h00000000; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0; in_valid = 0;
    total++; if (out_valid !== 1'b1 || is_nan !== 1'b1 || is_inf !== 1'b1 || z !== 48'd0) begin bad++; $display("FAIL b2b_short got=v%b n%b i%b z=%h exp=v1 n1 i1 z=0", out_valid, is_nan, is_inf, z); end
    release_rec();
  endtask

  task automatic test_reset_busy();
    int cyc;
    a = 32'h3FC00000; b = 32'h40000000; rm_in = 2'd3; in_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL rb_busy got=v%b r%b exp=v0 r0", out_valid, in_ready); end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rb_state got=v%b r%b exp=v0 r1", out_valid, in_ready); end
    total++; if (z !== 48'd0 || exp10 !== 10'd0 || rm !== 2'd0 || sign !== 1'b0) begin bad++; $display("FAIL rb_clear got=%h/%h/%0d/%b exp=0/0/0/0", z, exp10, rm, sign); end
    a = 32'hBF800000; b = 32'h3F800000; in_valid = 1;
    wait_valid(40, cyc);
    in_valid = 0;
    total++; if (cyc !== 7) begin bad++; $display("FAIL rb_latency got=%0d exp=7", cyc); end
    total++; if (z !== 48'h400000000000 || sign !== 1'b1 || rm !== 2'd3) begin bad++; $display("FAIL rb_result got=%h/%b/%0d exp=400000000000/1/3", z, sign, rm); end
    release_rec();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_special();
    test_sweep();
    test_backpressure();
    test_back_to_back();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
